// File: rtl/arm_decode.sv
// Control/decode unit of the single-cycle ARM datapath.
// Registers the instruction word and its condition-check result, then
// decodes them combinationally into register-file addresses, write
// enables, write data, operand/shift selects and the ALU opcode.
// Data-processing and B/BL are decoded; every other class only has its
// fields extracted and produces no writes.
module arm_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        cond_pass,
  input  logic [31:0] inst,
  input  logic [31:0] rn_out,
  input  logic [31:0] rm_out,
  input  logic [31:0] rs_out,
  input  logic [31:0] pc_out,
  input  logic [31:0] cpsr_out,
  input  logic [31:0] alu_out,
  output logic [3:0]  read_rn,
  output logic [3:0]  read_rm,
  output logic [3:0]  read_rs,
  output logic [3:0]  write_rd,
  output logic        rd_we,
  output logic        pc_we,
  output logic        cpsr_we,
  output logic [31:0] rd_in,
  output logic [31:0] pc_in,
  output logic [31:0] cpsr_in,
  output logic [1:0]  shiftee_sel,
  output logic [7:0]  immed_8_shiftee_in,
  output logic [31:0] immed_32_shiftee_in,
  output logic [1:0]  shifter_sel,
  output logic [3:0]  rotate_imm_shifter_in,
  output logic [4:0]  shift_imm_shifter_in,
  output logic [3:0]  barrel_sel,
  output logic [3:0]  alu_sel
);

  logic [31:0] ir;
  logic        cp;
  logic        valid;

  logic        is_dp;
  logic        is_branch;
  logic        is_test_op;
  logic [31:0] branch_off;

  // Operand read data is routed around this block; the condition field is
  // consumed upstream by the condition checker.
  logic unused_inputs;
  assign unused_inputs = ^{rn_out, rm_out, rs_out, ir[31:28]};

  // Instruction register, condition latch and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir    <= '0;
      cp    <= 1'b0;
      valid <= 1'b0;
    end else begin
      ir    <= inst;
      cp    <= cond_pass;
      valid <= 1'b1;
    end
  end

  assign is_dp      = (ir[27:26] == 2'b00);
  assign is_branch  = (ir[27:25] == 3'b101);
  // TST/TEQ/CMP/CMN only set flags, never write a register.
  assign is_test_op = (ir[24:23] == 2'b10);
  assign branch_off = {{6{ir[23]}}, ir[23:0], 2'b00};

  // Combinational decode of the captured instruction.
  always_comb begin
    read_rn               = '0;
    read_rm               = '0;
    read_rs               = '0;
    write_rd              = '0;
    rd_we                 = 1'b0;
    pc_we                 = 1'b0;
    cpsr_we               = 1'b0;
    rd_in                 = '0;
    pc_in                 = '0;
    cpsr_in               = '0;
    shiftee_sel           = 2'b00;
    immed_8_shiftee_in    = '0;
    immed_32_shiftee_in   = '0;
    shifter_sel           = 2'b00;
    rotate_imm_shifter_in = '0;
    shift_imm_shifter_in  = '0;
    barrel_sel            = '0;
    alu_sel               = '0;

    if (valid) begin
      read_rn               = ir[19:16];
      write_rd              = ir[15:12];
      read_rs               = ir[11:8];
      read_rm               = ir[3:0];
      alu_sel               = ir[24:21];
      immed_8_shiftee_in    = ir[7:0];
      rotate_imm_shifter_in = ir[11:8];
      shift_imm_shifter_in  = ir[11:7];

      if (is_dp) begin
        if (ir[25]) begin
          shiftee_sel = 2'b00;
          shifter_sel = 2'b00;
          barrel_sel  = 4'd9;
        end else if (!ir[4]) begin
          shiftee_sel = 2'b01;
          shifter_sel = 2'b01;
          // ROR #0 encodes RRX.
          if (ir[6:5] == 2'b11 && ir[11:7] == 5'd0) barrel_sel = 4'd8;
          else                                        barrel_sel = {2'b00, ir[6:5]};
        end else begin
          shiftee_sel = 2'b01;
          shifter_sel = 2'b10;
          barrel_sel  = {2'b01, ir[6:5]};
        end

        cpsr_we = cp & ir[20];
        cpsr_in = {alu_out[31], (alu_out == 32'd0), cpsr_out[29:0]};

        if (!is_test_op) begin
          rd_in = alu_out;
          if (ir[15:12] == 4'd15) begin
            pc_we = cp;
            pc_in = alu_out;
          end else begin
            rd_we = cp;
          end
        end
      end else if (is_branch) begin
        immed_32_shiftee_in = branch_off;
        shiftee_sel         = 2'b10;
        read_rn             = 4'd15;
        pc_we               = cp;
        pc_in               = pc_out + 32'd8 + branch_off;
        if (ir[24]) begin
          rd_we    = cp;
          write_rd = 4'd14;
          rd_in    = pc_out + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_arm_decode.sv
// Self-checking bench for arm_decode: a reference model pushes the full
// expected output set when each instruction is driven; the set is popped
// and compared field by field once the decode is visible.
module tb_arm_decode;

  typedef struct packed {
    logic [3:0]  read_rn;
    logic [3:0]  read_rm;
    logic [3:0]  read_rs;
    logic [3:0]  write_rd;
    logic        rd_we;
    logic        pc_we;
    logic        cpsr_we;
    logic [31:0] rd_in;
    logic [31:0] pc_in;
    logic [31:0] cpsr_in;
    logic [1:0]  shiftee_sel;
    logic [7:0]  immed_8;
    logic [31:0] immed_32;
    logic [1:0]  shifter_sel;
    logic [3:0]  rotate_imm;
    logic [4:0]  shift_imm;
    logic [3:0]  barrel_sel;
    logic [3:0]  alu_sel;
  } dec_t;

  logic        clk;
  logic        rst;
  logic        cond_pass;
  logic [31:0] inst, rn_out, rm_out, rs_out, pc_out, cpsr_out, alu_out;
  logic [3:0]  read_rn, read_rm, read_rs, write_rd;
  logic        rd_we, pc_we, cpsr_we;
  logic [31:0] rd_in, pc_in, cpsr_in;
  logic [1:0]  shiftee_sel;
  logic [7:0]  immed_8_shiftee_in;
  logic [31:0] immed_32_shiftee_in;
  logic [1:0]  shifter_sel;
  logic [3:0]  rotate_imm_shifter_in;
  logic [4:0]  shift_imm_shifter_in;
  logic [3:0]  barrel_sel;
  logic [3:0]  alu_sel;

  dec_t exp_q[$];
  int   vec_cnt;
  int   err_cnt;

  arm_decode dut (
    .clk(clk), .rst(rst), .cond_pass(cond_pass), .inst(inst),
    .rn_out(rn_out), .rm_out(rm_out), .rs_out(rs_out),
    .pc_out(pc_out), .cpsr_out(cpsr_out), .alu_out(alu_out),
    .read_rn(read_rn), .read_rm(read_rm), .read_rs(read_rs),
    .write_rd(write_rd), .rd_we(rd_we), .pc_we(pc_we), .cpsr_we(cpsr_we),
    .rd_in(rd_in), .pc_in(pc_in), .cpsr_in(cpsr_in),
    .shiftee_sel(shiftee_sel), .immed_8_shiftee_in(immed_8_shiftee_in),
    .immed_32_shiftee_in(immed_32_shiftee_in), .shifter_sel(shifter_sel),
    .rotate_imm_shifter_in(rotate_imm_shifter_in),
    .shift_imm_shifter_in(shift_imm_shifter_in),
    .barrel_sel(barrel_sel), .alu_sel(alu_sel)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference decode written from the instruction-set description.
  function automatic dec_t model(input logic [31:0] i, input logic c,
                                 input logic [31:0] alu, input logic [31:0] pc,
                                 input logic [31:0] cpsr);
    dec_t o;
    logic [31:0] off;
    o = '0;
    o.read_rn    = i[19:16];
    o.write_rd   = i[15:12];
    o.read_rs    = i[11:8];
    o.read_rm    = i[3:0];
    o.alu_sel    = i[24:21];
    o.immed_8    = i[7:0];
    o.rotate_imm = i[11:8];
    o.shift_imm  = i[11:7];
    if (i[27:26] == 2'b00) begin
      if (i[25]) begin
        o.barrel_sel = 4'd9;
      end else if (i[4]) begin
        o.shiftee_sel = 2'b01;
        o.shifter_sel = 2'b10;
        o.barrel_sel  = 4'd4 + {2'b00, i[6:5]};
      end else begin
        o.shiftee_sel = 2'b01;
        o.shifter_sel = 2'b01;
        o.barrel_sel  = (i[6:5] == 2'd3 && i[11:7] == 5'd0) ? 4'd8 : {2'b00, i[6:5]};
      end
      o.cpsr_we = c && i[20];
      o.cpsr_in = {alu[31], alu == 32'd0, cpsr[29:0]};
      if (!(i[24] && !i[23])) begin
        o.rd_in = alu;
        if (i[15:12] == 4'hF) begin
          o.pc_we = c;
          o.pc_in = alu;
        end else begin
          o.rd_we = c;
        end
      end
    end else if (i[27:25] == 3'b101) begin
      off = {{6{i[23]}}, i[23:0], 2'b00};
      o.immed_32    = off;
      o.shiftee_sel = 2'b10;
      o.read_rn     = 4'hF;
      o.pc_we       = c;
      o.pc_in       = pc + off + 32'd8;
      if (i[24]) begin
        o.rd_we    = c;
        o.write_rd = 4'hE;
        o.rd_in    = pc + 32'd4;
      end
    end
    return o;
  endfunction

  // Pop one expected set and compare every output field.
  task automatic compare_out(input string tag);
    dec_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_read_rn"},     {28'd0, read_rn},               {28'd0, e.read_rn});
    chk({tag, "_read_rm"},     {28'd0, read_rm},               {28'd0, e.read_rm});
    chk({tag, "_read_rs"},     {28'd0, read_rs},               {28'd0, e.read_rs});
    chk({tag, "_write_rd"},    {28'd0, write_rd},              {28'd0, e.write_rd});
    chk({tag, "_we"},          {29'd0, rd_we, pc_we, cpsr_we}, {29'd0, e.rd_we, e.pc_we, e.cpsr_we});
    chk({tag, "_rd_in"},       rd_in,                          e.rd_in);
    chk({tag, "_pc_in"},       pc_in,                          e.pc_in);
    chk({tag, "_cpsr_in"},     cpsr_in,                        e.cpsr_in);
    chk({tag, "_shiftee_sel"}, {30'd0, shiftee_sel},           {30'd0, e.shiftee_sel});
    chk({tag, "_immed_8"},     {24'd0, immed_8_shiftee_in},    {24'd0, e.immed_8});
    chk({tag, "_immed_32"},    immed_32_shiftee_in,            e.immed_32);
    chk({tag, "_shifter_sel"}, {30'd0, shifter_sel},           {30'd0, e.shifter_sel});
    chk({tag, "_rotate_imm"},  {28'd0, rotate_imm_shifter_in}, {28'd0, e.rotate_imm});
    chk({tag, "_shift_imm"},   {27'd0, shift_imm_shifter_in},  {27'd0, e.shift_imm});
    chk({tag, "_barrel_sel"},  {28'd0, barrel_sel},            {28'd0, e.barrel_sel});
    chk({tag, "_alu_sel"},     {28'd0, alu_sel},               {28'd0, e.alu_sel});
  endtask

  // Driver: present one instruction plus data inputs, then check after capture.
  task automatic apply(input string tag, input logic [31:0] i, input logic c,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] cpsr);
    @(negedge clk);
    rst       = 1'b0;
    inst      = i;
    cond_pass = c;
    alu_out   = alu;
    pc_out    = pc;
    cpsr_out  = cpsr;
    exp_q.push_back(model(i, c, alu, pc, cpsr));
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic do_reset(input string tag, input int edges);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back('0);
    repeat (edges) @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    logic [31:0] ri;
    vec_cnt   = 0;
    err_cnt   = 0;
    rst       = 1'b1;
    cond_pass = 1'b1;
    inst      = 32'hE2011002;
    rn_out    = 32'h1111_1111;
    rm_out    = 32'h2222_2222;
    rs_out    = 32'h3333_3333;
    pc_out    = 32'h0;
    cpsr_out  = 32'h0;
    alu_out   = 32'h3;

    do_reset("reset", 2);

    // Directed vectors with hand-derived spot values.
    apply("and_imm", 32'hE2011002, 1'b1, 32'h3, 32'h0, 32'h0);
    chk("and_imm_barrel", {28'd0, barrel_sel}, 32'd9);
    chk("and_imm_rd_in", rd_in, 32'h3);
    chk("and_imm_rd_we", {31'd0, rd_we}, 32'd1);

    apply("bic_imm", 32'hE3C89CFF, 1'b1, 32'h55, 32'h0, 32'h0);
    chk("bic_imm_rot", {28'd0, rotate_imm_shifter_in}, 32'hC);
    chk("bic_imm_alu", {28'd0, alu_sel}, 32'hE);

    apply("cmp_reg", 32'hE1570008, 1'b1, 32'h0, 32'h0, 32'h0);
    chk("cmp_reg_cpsr_in", cpsr_in, 32'h4000_0000);
    chk("cmp_reg_rd_we", {31'd0, rd_we}, 32'd0);
    chk("cmp_reg_cpsr_we", {31'd0, cpsr_we}, 32'd1);

    apply("add_lsl", 32'hE0859185, 1'b1, 32'h8000_0000, 32'h0, 32'h2000_0000);
    chk("add_lsl_shift_imm", {27'd0, shift_imm_shifter_in}, 32'd3);
    chk("add_lsl_barrel", {28'd0, barrel_sel}, 32'd0);

    apply("sub_lsr", 32'hE049A228, 1'b1, 32'h7, 32'h0, 32'h0);
    chk("sub_lsr_barrel", {28'd0, barrel_sel}, 32'd1);

    apply("mov_ror_rs", 32'hE1A0C374, 1'b1, 32'h9, 32'h0, 32'h0);
    chk("mov_ror_rs_barrel", {28'd0, barrel_sel}, 32'd7);
    chk("mov_ror_rs_shifter", {30'd0, shifter_sel}, 32'd2);

    apply("mov_rrx", 32'hE1A00060, 1'b1, 32'h1, 32'h0, 32'h0);
    chk("mov_rrx_barrel", {28'd0, barrel_sel}, 32'd8);

    apply("mov_pc", 32'hE1A0F00E, 1'b1, 32'h0000_0200, 32'h0, 32'h0);
    chk("mov_pc_pc_in", pc_in, 32'h200);
    chk("mov_pc_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'b010);

    apply("bl", 32'hEB00000B, 1'b1, 32'h0, 32'h100, 32'h0);
    chk("bl_pc_in", pc_in, 32'h134);
    chk("bl_rd_in", rd_in, 32'h104);
    chk("bl_write_rd", {28'd0, write_rd}, 32'hE);
    chk("bl_immed_32", immed_32_shiftee_in, 32'h2C);

    apply("bl_nopass", 32'hEB00000B, 1'b0, 32'h0, 32'h100, 32'h0);
    chk("bl_nopass_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);
    chk("bl_nopass_immed_32", immed_32_shiftee_in, 32'h2C);

    // Backward branch wraps below zero.
    apply("b_back", 32'hEAFFFFFE, 1'b1, 32'h0, 32'h4, 32'h0);
    chk("b_back_pc_in", pc_in, 32'h4);

    apply("ldr_nop", 32'hE5912004, 1'b1, 32'h5, 32'h0, 32'h0);
    chk("ldr_nop_we", {29'd0, rd_we, pc_we, cpsr_we}, 32'd0);

    apply("adds_nopass", 32'hE0912003, 1'b0, 32'h5, 32'h0, 32'h0);

    // Reset mid-stream clears all outputs after one edge.
    do_reset("reset_mid", 1);

    // Randomised instructions across all classes.
    for (int n = 0; n < 60; n++) begin
      ri = $urandom;
      case ($urandom_range(0, 3))
        0: ri[27:25] = 3'b101;
        1: ri[27:26] = 2'b00;
        2: begin ri[27:25] = 3'b000; ri[11:4] = {5'd0, 2'b11, 1'b0}; end
        default: ;
      endcase
      apply($sformatf("rnd%0d", n), ri, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom, $urandom);
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
